prefetch_queue: RTL and testbench

Instruction prefetch queue between the instruction memory port and the IF/ID pipeline register. Issues sequential word fetches ahead of the decoder, buffers returned instructions with their PC+4, and presents them to the IF stage through a valid/ready handshake. A branch/jump redirect from EX flushes buffered words, discards in-flight responses, and restarts fetch at the new target.

---
 rtl/prefetch_queue.sv | 170 +++++++++++++++++
 tb/tb_prefetch_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue between the instruction memory port and IF/ID.
// It issues sequential word fetches ahead of the decoder and buffers the
// returned words together with their PC+4. A redirect from EX flushes the
// buffer, discards in-flight responses and restarts fetch at the new target.
//
// Optional feature macro: PREFETCH_QUEUE_BYPASS_EN. When it is defined, a
// response that arrives while the queue is empty is forwarded combinationally
// to the IF stage.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   mem_req, mem_addr            fetch request and its word address (comb)
//   mem_gnt                      request accepted this cycle
//   mem_rvalid, mem_rdata        in-order response and its instruction word
//   redirect, redirect_pc        taken branch/jump and its new target
//   inst_valid, inst, inst_pc4   head entry presented to the IF stage
//   inst_ready                   consumer accepts the head entry
module prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc4,
  input  logic        inst_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]    state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [PW-1:0] head, head_n, tail, tail_n;
  logic [CW-1:0] count, count_n;
  logic [CW-1:0] outstanding, outstanding_n;
  logic [CW-1:0] discard, discard_n;

  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc4_q  [DEPTH];

  logic [CW:0]   occupancy;
  logic          req_int;
  logic          grant;
  logic          head_valid;
  logic          bypass_hit;
  logic          bypass_take;
  logic          deq;
  logic          wr_en;
  logic [31:0]   resp_pc4;

  // Request credit, handshakes and head presentation.
  always_comb begin
    occupancy  = {1'b0, count} + {1'b0, outstanding};
    req_int    = (state == FETCH) && (occupancy < (CW+1)'(DEPTH)) && !redirect;
    grant      = req_int && mem_gnt;
    mem_req    = req_int && !rst;
    mem_addr   = fetch_pc;
    head_valid = (count != '0);
    // In FETCH every outstanding request belongs to the current stream, so
    // the oldest one was issued at fetch_pc - 4*outstanding.
    resp_pc4   = fetch_pc - (32'(outstanding) << 2) + 32'd4;
`ifdef PREFETCH_QUEUE_BYPASS_EN
    bypass_hit = !head_valid && (state == FETCH) && !redirect && mem_rvalid;
`else
    bypass_hit = 1'b0;
`endif
    bypass_take = bypass_hit && inst_ready;
    inst_valid  = !rst && (head_valid || bypass_hit);
    inst        = 32'd0;
    inst_pc4    = 32'd0;
    if (inst_valid) begin
      if (head_valid) begin
        inst     = inst_q[head];
        inst_pc4 = pc4_q[head];
      end else begin
        inst     = mem_rdata;
        inst_pc4 = resp_pc4;
      end
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    head_n        = head;
    tail_n        = tail;
    count_n       = count;
    outstanding_n = outstanding;
    discard_n     = discard;
    deq           = 1'b0;
    wr_en         = 1'b0;
    case (state)
      FETCH: begin
        if (redirect) begin
          // A response arriving in the redirect cycle is dropped here.
          count_n       = '0;
          head_n        = '0;
          tail_n        = '0;
          fetch_pc_n    = redirect_pc;
          discard_n     = outstanding - CW'(mem_rvalid);
          outstanding_n = outstanding - CW'(mem_rvalid);
          state_n       = (discard_n != '0) ? DRAIN : FETCH;
        end else begin
          deq           = head_valid && inst_ready;
          wr_en         = mem_rvalid && !bypass_take;
          if (deq)   head_n = head + PW'(1);
          if (wr_en) tail_n = tail + PW'(1);
          count_n       = count + CW'(wr_en) - CW'(deq);
          outstanding_n = outstanding + CW'(grant) - CW'(mem_rvalid);
          if (grant) fetch_pc_n = fetch_pc + 32'd4;
        end
      end
      DRAIN: begin
        discard_n     = discard - CW'(mem_rvalid);
        outstanding_n = outstanding - CW'(mem_rvalid);
        if (redirect) begin
          fetch_pc_n = redirect_pc;
          count_n    = '0;
          head_n     = '0;
          tail_n     = '0;
        end
        if (discard_n == '0) state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      head        <= head_n;
      tail        <= tail_n;
      count       <= count_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
    end
  end

  // Queue storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      inst_q[tail] <= mem_rdata;
      pc4_q[tail]  <= resp_pc4;
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomized bench for prefetch_queue. A memory model returns in-order
// responses with random latency; a queue-based reference model predicts the
// request and head outputs every cycle.
module tb_prefetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc4;
  logic        inst_ready;

  prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc4(inst_pc4),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: buffered entries, in-flight count, words to discard.
  logic [31:0] mq_inst[$];
  logic [31:0] mq_pc4[$];
  int          m_out;
  int          m_disc;
  logic [31:0] m_pc;

  // Memory model: pending request addresses and their earliest return cycle.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  logic [31:0] resp_addr;

  // Stimulus knobs.
  int          gnt_pct, ready_pct, rv_pct, redir_pct, lat_max;
  bit          want_redir;
  bit          want_out2;
  logic [31:0] want_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mq_inst.delete();
    mq_pc4.delete();
    pend_addr.delete();
    pend_due.delete();
    m_out  = 0;
    m_disc = 0;
    m_pc   = 32'h0000_0000;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    redirect   = 1'b0;
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b1;
    inst_ready = 1'b1;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc4", inst_pc4, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    cyc++;
  endtask

  task automatic run_cycle();
    logic        exp_req, exp_valid, grant, deq, take;
    logic [31:0] exp_inst, exp_pc4, wv;
    int          lat;
    // Drive this cycle's inputs.
    mem_gnt    = ($urandom_range(99) < gnt_pct);
    inst_ready = ($urandom_range(99) < ready_pct);
    mem_rdata  = $urandom;
    mem_rvalid = 1'b0;
    resp_addr  = 32'd0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc && $urandom_range(99) < rv_pct) begin
      mem_rvalid = 1'b1;
      resp_addr  = pend_addr[0];
    end
    redirect    = ($urandom_range(99) < redir_pct);
    wv          = $urandom;
    redirect_pc = {wv[31:2], 2'b00};
    if (want_redir && (!want_out2 || (m_out == 2 && m_disc == 0))) begin
      redirect    = 1'b1;
      redirect_pc = want_pc;
      want_redir  = 1'b0;
    end
    #1;
    // Expected outputs.
    exp_req   = (m_disc == 0) && (mq_inst.size() + m_out < DEPTH) && !redirect;
    exp_valid = (mq_inst.size() > 0);
    exp_inst  = exp_valid ? mq_inst[0] : 32'd0;
    exp_pc4   = exp_valid ? mq_pc4[0]  : 32'd0;
`ifdef PREFETCH_QUEUE_BYPASS_EN
    if (!exp_valid && m_disc == 0 && !redirect && mem_rvalid) begin
      exp_valid = 1'b1;
      exp_inst  = mem_rdata;
      exp_pc4   = resp_addr + 32'd4;
    end
`endif
    check("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) check("mem_addr", mem_addr, m_pc);
    check("inst_valid", 32'(inst_valid), 32'(exp_valid));
    check("inst", inst, exp_inst);
    check("inst_pc4", inst_pc4, exp_pc4);
    @(posedge clk);
    // Advance memory and reference model with this cycle's handshakes.
    grant = exp_req && mem_gnt;
    if (mem_rvalid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (grant) begin
      lat = $urandom_range(lat_max, 1);
      pend_addr.push_back(m_pc);
      pend_due.push_back(cyc + lat);
    end
    if (redirect) begin
      m_disc = m_out - int'(mem_rvalid);
      m_out  = m_disc;
      mq_inst.delete();
      mq_pc4.delete();
      m_pc   = redirect_pc;
    end else if (m_disc != 0) begin
      if (mem_rvalid) begin
        m_disc--;
        m_out--;
      end
    end else begin
      deq  = (mq_inst.size() > 0) && inst_ready;
      take = 1'b0;
`ifdef PREFETCH_QUEUE_BYPASS_EN
      take = (mq_inst.size() == 0) && mem_rvalid && inst_ready;
`endif
      if (deq) begin
        void'(mq_inst.pop_front());
        void'(mq_pc4.pop_front());
      end
      if (mem_rvalid && !take) begin
        mq_inst.push_back(mem_rdata);
        mq_pc4.push_back(resp_addr + 32'd4);
      end
      if (mem_rvalid) m_out--;
      if (grant) begin
        m_out++;
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_knobs(input int g, input int r, input int v, input int d, input int l);
    gnt_pct = g; ready_pct = r; rv_pct = v; redir_pct = d; lat_max = l;
  endtask

  initial begin
    rst = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    redirect = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
    want_redir = 1'b0; want_out2 = 1'b0; want_pc = 32'd0;
    model_clear();
    set_knobs(100, 100, 100, 0, 1);
    @(posedge clk);
    #1;
    do_reset();

    // Streaming with 1-cycle latency and an always-ready consumer.
    for (int i = 0; i < 20; i++) run_cycle();

    // Consumer stall fills the queue, then release drains it in order.
    set_knobs(100, 0, 100, 0, 1);
    for (int i = 0; i < 10; i++) run_cycle();
    set_knobs(100, 100, 100, 0, 1);
    for (int i = 0; i < 10; i++) run_cycle();

    // Redirect to 0x100 while two requests are in flight.
    set_knobs(100, 100, 100, 0, 3);
    want_redir = 1'b1; want_out2 = 1'b1; want_pc = 32'h0000_0100;
    for (int i = 0; i < 40; i++) run_cycle();

    // Redirect to the top word so the fetch address wraps to zero.
    set_knobs(100, 100, 100, 0, 1);
    want_redir = 1'b1; want_out2 = 1'b0; want_pc = 32'hFFFF_FFFC;
    for (int i = 0; i < 12; i++) run_cycle();

    // Reset in the middle of traffic.
    set_knobs(70, 60, 70, 5, 4);
    for (int i = 0; i < 15; i++) run_cycle();
    do_reset();

    // Randomized mix of stalls, grants, latencies and redirects.
    for (int p = 0; p < 6; p++) begin
      set_knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 10)),
                int'($urandom_range(100, 30)), int'($urandom_range(12, 2)),
                int'($urandom_range(5, 1)));
      for (int i = 0; i < 500; i++) run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
